// File: rtl/arf028b032e2r2w0cbbehraa4acw_msff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages of DWIDTH bits with
// bubble collapse, synchronous flush and a popcount occupancy output.
module arf028b032e2r2w0cbbehraa4acw_msff_pipe #(
  parameter int DWIDTH     = 1,
  parameter int DEPTH      = 2,
  parameter bit RESET_DATA = 1'b1,
  parameter int CNTW       = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [CNTW-1:0]   occupancy
);

  // Handshake: an entry moves across a port on a rising edge only when that
  // port's valid and ready are both high; valid never depends on ready.

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
    assign in_ready       = out_ready & ~flush;
    assign occupancy      = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0]  v;
    logic [DWIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0]  rdy;

    // A stage can take a new entry if it or any stage downstream has a hole,
    // or the consumer is draining the last stage.
    always_comb begin : ready_chain
      logic acc;
      acc = out_ready;
      rdy = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        acc    = ~v[i] | acc;
        rdy[i] = acc;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v <= '0;
        if (RESET_DATA) begin
          for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end
      end else if (flush) begin
        v <= '0;
      end else begin
        if (rdy[0]) begin
          v[0] <= in_valid;
          if (in_valid) d[0] <= in_data;
        end
        // Data only moves with a valid entry so bubbles never toggle registers.
        for (int i = 1; i < DEPTH; i++) begin
          if (rdy[i]) begin
            v[i] <= v[i-1];
            if (v[i-1]) d[i] <= d[i-1];
          end
        end
      end
    end

    always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CNTW'(v[i]);
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
  end

endmodule

// File: tb/tb_arf028b032e2r2w0cbbehraa4acw_msff_pipe.sv
// Bench for the elastic pipeline: a queue-based reference model scores the
// DEPTH=3 instance; DEPTH=4 bubble and DEPTH=0 pass-through are directed.
module tb_arf028b032e2r2w0cbbehraa4acw_msff_pipe;
  localparam int W = 8;
  localparam int D = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // main DEPTH=3 instance
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0] occupancy;

  arf028b032e2r2w0cbbehraa4acw_msff_pipe #(.DWIDTH(W), .DEPTH(D), .RESET_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy));

  // DEPTH=4 instance for bubble collapse
  logic b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [W-1:0] b_in_data = '0;
  logic b_in_ready, b_out_valid;
  logic [W-1:0] b_out_data;
  logic [2:0] b_occupancy;

  arf028b032e2r2w0cbbehraa4acw_msff_pipe #(.DWIDTH(W), .DEPTH(4), .RESET_DATA(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .occupancy(b_occupancy));

  // DEPTH=0 pass-through instance
  logic p_flush = 1'b0, p_in_valid = 1'b0, p_out_ready = 1'b0;
  logic [W-1:0] p_in_data = '0;
  logic p_in_ready, p_out_valid;
  logic [W-1:0] p_out_data;
  logic [0:0] p_occupancy;

  arf028b032e2r2w0cbbehraa4acw_msff_pipe #(.DWIDTH(W), .DEPTH(0), .RESET_DATA(1'b1)) dut_p (
    .clk(clk), .rst(rst), .flush(p_flush), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_data(p_in_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .occupancy(p_occupancy));

  int total = 0, bad = 0, rx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver: offers the head of in_q, retires it once the handshake lands
  logic [W-1:0] in_q[$];
  bit offer_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (offer_en && in_q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = in_q[0];
    end else begin
      in_valid = 1'b0;
    end
  end
  always @(negedge clk)
    if (!rst && in_valid && in_ready) void'(in_q.pop_front());

  // scoreboard: entries in flight with their acceptance cycle
  logic [W-1:0] exp_q[$];
  int ts_q[$];

  always @(negedge clk) begin : monitor
    int sz;
    bit e_ov, e_ir;
    sz   = exp_q.size();
    e_ir = !flush && (out_ready || sz < D);
    e_ov = (sz > 0) && (cyc - ts_q[0] >= D);
    check("occupancy", 32'(occupancy), 32'(sz));
    check("in_ready", 32'(in_ready), 32'(e_ir));
    check("out_valid", 32'(out_valid), 32'(e_ov));
    if (rst || flush) begin
      exp_q.delete();
      ts_q.delete();
    end else begin
      if (e_ov && out_ready) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        void'(ts_q.pop_front());
        rx_cnt++;
      end
      if (in_valid && e_ir) begin
        exp_q.push_back(in_data);
        ts_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_q.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int rx0;
    // reset with an entry offered
    in_q.push_back(8'hA5);
    offer_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_out_data", 32'(out_data), 32'h0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // streaming
    tick();
    out_ready = 1'b1;
    rx0 = rx_cnt;
    for (int k = 1; k <= 8; k++) in_q.push_back(W'(k));
    wait_drain("stream_drain");
    check("stream_count", 32'(rx_cnt - rx0), 32'd9);

    // back-pressure then release
    tick();
    out_ready = 1'b0;
    for (int k = 16; k <= 20; k++) in_q.push_back(W'(k));
    repeat (6) tick();
    check("bp_accepted", 32'(in_q.size()), 32'd2);
    out_ready = 1'b1;
    rx0 = rx_cnt;
    wait_drain("bp_drain");
    check("bp_count", 32'(rx_cnt - rx0), 32'd5);

    // flush with input offered and consumer ready
    tick();
    out_ready = 1'b0;
    for (int k = 48; k <= 51; k++) in_q.push_back(W'(k));
    repeat (6) tick();
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    wait_drain("flush_drain");

    // randomized traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      tick();
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      offer_en  = ($urandom_range(0, 3) != 0);
      if (in_q.size() < 4) in_q.push_back(W'($urandom_range(0, 255)));
    end
    tick();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    offer_en = 1'b1;
    wait_drain("rand_drain");

    // bubble collapse on DEPTH=4
    tick();
    b_in_valid = 1'b1;
    b_in_data = 8'h20;
    tick();
    b_in_valid = 1'b0;
    tick();
    tick();
    b_in_valid = 1'b1;
    b_in_data = 8'h21;
    tick();
    b_in_valid = 1'b0;
    repeat (3) begin
      tick();
      check("bub_in_ready_stall", 32'(b_in_ready), 32'd1);
    end
    @(negedge clk);
    check("bub_occ2", 32'(b_occupancy), 32'd2);
    check("bub_in_ready", 32'(b_in_ready), 32'd1);
    check("bub_out_valid", 32'(b_out_valid), 32'd1);
    check("bub_head", 32'(b_out_data), 32'h20);
    b_out_ready = 1'b1;
    @(negedge clk);
    check("bub_second_valid", 32'(b_out_valid), 32'd1);
    check("bub_second", 32'(b_out_data), 32'h21);
    check("bub_occ1", 32'(b_occupancy), 32'd1);
    @(negedge clk);
    check("bub_empty_occ", 32'(b_occupancy), 32'd0);
    check("bub_empty_valid", 32'(b_out_valid), 32'd0);

    // DEPTH=0 pass-through
    for (int n = 0; n < 20; n++) begin
      tick();
      p_in_valid  = 1'($urandom_range(0, 1));
      p_out_ready = 1'($urandom_range(0, 1));
      p_flush     = ($urandom_range(0, 3) == 0);
      p_in_data   = (n % 2 == 0) ? 8'h3C : W'($urandom_range(0, 255));
      #1;
      check("pt_out_valid", 32'(p_out_valid), 32'(p_in_valid));
      check("pt_out_data", 32'(p_out_data), 32'(p_in_data));
      check("pt_in_ready", 32'(p_in_ready), 32'(p_out_ready & ~p_flush));
      check("pt_occ", 32'(p_occupancy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
